// File: rtl/mem_responder.sv
// ============================================================================
// mem_responder: single-port 16-bit memory responder with a valid/ready image
// loader, an output-port register and a halt flag. Rev 1.0
// ============================================================================
`default_nettype none

module mem_responder #(
  parameter int MEM_DEPTH  = 4096,
  parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  mem_enable,
  input  logic                  mem_read_enable,
  input  logic                  mem_write_enable,
  input  logic [ADDR_WIDTH-1:0] mem_address,
  input  logic [DATA_WIDTH-1:0] mem_data_in,
  output logic [DATA_WIDTH-1:0] mem_data_out,
  input  logic                  load_valid,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  output logic                  load_ready,
  output logic                  cpu_hold,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  halt
);

  localparam logic [ADDR_WIDTH-1:0] OUT_ADDR  = ADDR_WIDTH'(MEM_DEPTH - 2);
  localparam logic [ADDR_WIDTH-1:0] HALT_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR  = ADDR_WIDTH'(MEM_DEPTH - 1);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_load_ptr;
  logic                    r_load_ready;
  logic [DATA_WIDTH-1:0]   r_data_out;
  logic [DATA_WIDTH-1:0]   r_out_port;
  logic                    r_halt;
  logic [DATA_WIDTH-1:0]   r_mem [MEM_DEPTH];

  logic                    w_load_xfer;
  logic                    w_load_done;
  logic                    w_active;
  logic                    w_acc_rd;
  logic                    w_run_wr;
  logic                    w_is_out;
  logic                    w_is_halt;
  logic                    w_halt_set;
  logic                    w_ram_we;
  logic [ADDR_WIDTH-1:0]   w_ram_addr;
  logic [DATA_WIDTH-1:0]   w_ram_wdata;

  assign w_load_xfer = (r_state == S_LOAD) && load_valid && r_load_ready;
  assign w_load_done = w_load_xfer && (load_last || (r_load_ptr == LAST_PTR));
  assign w_active    = (r_state == S_RUN) || (r_state == S_HALT);
  assign w_acc_rd    = w_active && mem_enable && mem_read_enable && !mem_write_enable;
  // Writes are only honoured in RUN; HALT freezes RAM and both registers.
  assign w_run_wr    = (r_state == S_RUN) && mem_enable && mem_write_enable;
  assign w_is_out    = (mem_address == OUT_ADDR);
  assign w_is_halt   = (mem_address == HALT_ADDR);
  assign w_halt_set  = w_run_wr && w_is_halt && (mem_data_in != '0);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_LOAD:  if (w_load_done) w_state_nxt = S_RUN;
      S_RUN:   if (w_halt_set)  w_state_nxt = S_HALT;
      S_HALT:  w_state_nxt = S_HALT;
      default: w_state_nxt = S_LOAD;
    endcase
  end

  always_comb begin
    w_ram_we    = 1'b0;
    w_ram_addr  = r_load_ptr;
    w_ram_wdata = load_data;
    if (w_load_xfer) begin
      w_ram_we = 1'b1;
    end else if (w_run_wr && !w_is_out && !w_is_halt) begin
      w_ram_we    = 1'b1;
      w_ram_addr  = mem_address;
      w_ram_wdata = mem_data_in;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= S_LOAD;
      r_load_ptr   <= '0;
      r_load_ready <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_load_ready <= (w_state_nxt == S_LOAD);
      // Pointer parks at the last word rather than wrapping on a full image.
      if (w_load_xfer && (r_load_ptr != LAST_PTR)) r_load_ptr <= r_load_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_data_out <= '0;
      r_out_port <= '0;
      r_halt     <= 1'b0;
    end else begin
      if (w_acc_rd) begin
        if (w_is_out)       r_data_out <= r_out_port;
        else if (w_is_halt) r_data_out <= {{(DATA_WIDTH-1){1'b0}}, r_halt};
        else                r_data_out <= r_mem[mem_address];
      end
      if (w_run_wr && w_is_out) r_out_port <= mem_data_in;
      if (w_halt_set)           r_halt     <= 1'b1;
    end
  end

  // RAM carries no reset so an image survives a reset mid-load.
  always_ff @(posedge clock) begin
    if (w_ram_we) r_mem[w_ram_addr] <= w_ram_wdata;
  end

  assign mem_data_out = r_data_out;
  assign load_ready   = r_load_ready;
  assign cpu_hold     = (r_state == S_LOAD);
  assign out_port     = r_out_port;
  assign halt         = r_halt;

endmodule

`default_nettype wire

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Synthesizable memory-side responder for the CPU's single-port 16-bit memory-controller interface: enable, read enable, write enable, 12-bit word address, 16-bit data in and out.
- Replaces the behavioural memory plus file preload. Program image arrives over a valid/ready load stream; CPU held via cpu_hold until load completes.
- Two memory-mapped registers at top of address space: output port and halt flag.

Parameters:
MEM_DEPTH, 4096, number of 16-bit words; must be a power of two
ADDR_WIDTH, $clog2(MEM_DEPTH) = 12, word address width
DATA_WIDTH, 16, word width
OUT_ADDR, MEM_DEPTH-2 (12'hFFE), address of the output-port register
HALT_ADDR, MEM_DEPTH-1 (12'hFFF), address of the halt register

Ports:
clock  in  1  system clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset (asserted at 0)
mem_enable  in  1  access qualifier from memory controller
mem_read_enable  in  1  read request (valid only with mem_enable)
mem_write_enable  in  1  write request (valid only with mem_enable)
mem_address  in  ADDR_WIDTH  word address
mem_data_in  in  DATA_WIDTH  write data
mem_data_out  out  DATA_WIDTH  registered read data
load_valid  in  1  load stream word valid
load_data  in  DATA_WIDTH  load stream word
load_last  in  1  marks final load word
load_ready  out  1  responder accepts a load word
cpu_hold  out  1  holds CPU in reset while high
out_port  out  DATA_WIDTH  output-port register
halt  out  1  set when CPU writes nonzero to HALT_ADDR

Behaviour:
- Reset (reset=0, async):
  - State = LOAD, load_ptr = 0.
  - mem_data_out = 0, out_port = 0, halt = 0, cpu_hold = 1, load_ready = 0.
  - RAM contents not cleared.
- load_ready = 1 exactly when state = LOAD and reset is deasserted. Registered: first high on the first clock edge after reset release.
- FSM states: LOAD, RUN, HALT.
- LOAD:
  - On load_valid & load_ready: ram[load_ptr] <= load_data; load_ptr increments.
  - Transition to RUN after the transfer where load_last = 1, or where load_ptr = MEM_DEPTH-1. A full image ends the load; the pointer never wraps.
  - Words load_ptr = OUT_ADDR/HALT_ADDR are written to RAM, not to the registers.
  - All mem_* requests are ignored; mem_data_out holds its value.
  - cpu_hold = 1.
- RUN:
  - cpu_hold = 0 from the cycle after the last load transfer.
  - load_ready = 0; load stream ignored.
- Access decode (RUN and HALT), evaluated on the rising edge:
  - mem_enable = 0: no action; mem_data_out holds.
  - Read (en & rd_en & !wr_en): mem_data_out <= ram[addr]. For OUT_ADDR returns out_port; for HALT_ADDR returns {15'b0, halt}. Read latency is 1 cycle: data visible after the edge that sampled the request.
  - Write (en & wr_en): ram[addr] <= mem_data_in, except:
    - OUT_ADDR: writes out_port only.
    - HALT_ADDR: sets halt if data != 0; a zero write does nothing.
    - MMIO addresses are not RAM-backed.
  - rd_en & wr_en together: the write is performed; mem_data_out holds (no read).
  - en with neither rd_en nor wr_en: no action.
  - Read the cycle after a write to the same address returns the new data (no bypass needed; array is updated at the edge).
- HALT:
  - Entered the cycle after a nonzero write to HALT_ADDR; halt = 1.
  - All writes ignored, including RAM, out_port and HALT_ADDR. Reads are still served.
  - cpu_hold stays 0. Exit only via reset.
- Reset mid-load: the pointer restarts at 0 and previously loaded words remain in RAM. Reset in RUN/HALT returns to LOAD.
- Addresses are always in range: a 12-bit address into 4096 words, so there is no out-of-range case.

Test Plan:
- Reset release, stream 4 words 0x1111, 0x2222, 0x3333, 0x4444 (last on 4th), with load_valid toggled every other cycle -> ram[0..3] hold those values; load_ready falls and cpu_hold falls the cycle after the 4th transfer; no write occurs on cycles with load_valid low.
- RUN read of addr 2 -> mem_data_out = 0x3333 exactly one edge later. Then en=0 for 3 cycles -> mem_data_out stays 0x3333.
- Write 0xBEEF to addr 0x010, read it back next cycle -> 0xBEEF. Simultaneous rd_en & wr_en of 0x1234 to 0x010 -> ram = 0x1234, mem_data_out unchanged.
- Write 0x00A5 to 0xFFE -> out_port = 0x00A5, read 0xFFE returns 0x00A5. Write 0 to 0xFFF -> halt stays 0. Write 1 to 0xFFF -> halt = 1, read 0xFFF = 0x0001. Subsequent write 0x5555 to 0x010 -> read returns 0x1234.
- Stream 4096 words with load_last never asserted -> RUN entered after word 4095, ptr does not wrap, ram[0] is not overwritten by extra load_valid pulses.
- Assert reset after 2 of 4 load words (0xAAAA, 0xBBBB), then reload 0xCCCC (last) -> ram[0] = 0xCCCC, ram[1] = 0xBBBB, cpu_hold 1 during reset, outputs at reset values immediately (async).
